icache_responder: RTL and testbench
===================================

# icache_responder

Instruction-side memory responder serving the fetch stage: a direct-mapped, read-only instruction cache that answers the per-cycle fetch address with an instruction word in the same cycle on a hit. On a miss it raises a stall toward fetch and refills the whole line word-by-word from a backing memory over a req/ack bus. It sits between the fetch stage and the main instruction memory port.

## Interface
- LINE_WORDS, 4, words per line; power of two, ≥2
- NUM_LINES, 64, lines in cache; power of two
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  reset RESET, asynchronous, active-low; clock CLK
- Addr_fIF  in  32  fetch address; bits [1:0] ignored
- Instr_2IF  out  32  instruction word for Addr_fIF (combinational)
- Stall_2IF  out  1  high while the addressed word is not available
- Flush  in  1  invalidate all lines (e.g. after self-modifying store / SYSCALL)
- Mem_Req  out  1  backing-memory read request
- Mem_Addr  out  32  word address of request, bits [1:0]=0
- Mem_Ack  in  1  Mem_Data valid, request consumed
- Mem_Data  in  32  read data
- Hit_Count, Miss_Count  out  32  statistics (only with ICACHE_STATS_EN)

## Operation
- Field split: OFF = log2(LINE_WORDS)+2 bits, IDX = log2(NUM_LINES) bits, TAG = 32-OFF-IDX bits; word select = Addr_fIF[OFF-1:2].
- Storage: data array NUM_LINES×LINE_WORDS×32, tag array, valid bit per line; data/tag read combinationally.
- Hit = state IDLE and valid[idx] and tag[idx]==addr tag. Hit: Instr_2IF = word, Stall_2IF = 0.
- Not hit: Instr_2IF = 32'h0 (NOP bubble), Stall_2IF = 1.
- FSM states: IDLE, REFILL.
  - IDLE, miss: latch line base (Addr_fIF with offset zeroed), word counter=0, Miss_Count++, go REFILL.
  - REFILL: Mem_Req=1, Mem_Addr = base + 4×counter. On Mem_Ack write Mem_Data into data[idx][counter], counter++. On ack of word LINE_WORDS-1: write tag, set valid (unless flush seen), drop Mem_Req, go IDLE.
- Fetch holds Addr_fIF stable while Stall_2IF=1; lookup in IDLE after refill then hits.
- Flush in IDLE: all valid bits cleared on that edge; simultaneous miss still starts refill.
- Flush in REFILL: refill runs to completion (bus transaction never aborted); line is NOT marked valid; a sticky flag records this. Next IDLE cycle misses again.
- Counters wrap modulo 2^32.

## Timing
- Hit latency 0 cycles (combinational).
- Miss: Stall_2IF high in detect cycle plus every REFILL cycle; with Mem_Ack every cycle, stall = 1+LINE_WORDS cycles, hit on following cycle.
- Mem_Req asserted first cycle after detect; Req/Addr held stable until Mem_Ack; next word request asserted the cycle after an ack (Req stays high between words).
- Mem_Ack while Mem_Req=0 ignored.
- Reset values: state IDLE, all valid 0, counter 0, Mem_Req 0, Mem_Addr 0, Hit_Count/Miss_Count 0; hence Stall_2IF=1, Instr_2IF=0 during/after reset until first line filled.
- Reset mid-refill: Mem_Req drops asynchronously, partial line discarded (valid stays 0).

## Configuration
- ICACHE_STATS_EN defined: Hit_Count increments each cycle with Stall_2IF=0; Miss_Count increments on each IDLE→REFILL; both ports present.
- Undefined: counters and ports absent; all other behaviour identical.

## Structure
- Shared package icache_pkg: FSM state encoding (IDLE, REFILL), LINE_WORDS/NUM_LINES defaults, derived OFF/IDX/TAG width localparams, NOP constant 32'h0.
- One sub-module: icache_refill_ctrl (FSM, word counter, Mem_Req/Mem_Addr, flush-sticky flag); arrays and lookup in top.

## Test plan
- Reset, Addr_fIF=0xBFC00000, Mem_Ack every cycle -> Mem_Addr 0xBFC00000,04,08,0C; Stall_2IF high 5 cycles; then Instr_2IF = word returned for 0xBFC00000, stall 0.
- After fill, sweep 0xBFC00004..0C -> zero stall, correct words, no Mem_Req.
- Mem_Ack delayed 3 cycles per word -> Mem_Addr stable through wait, stall held, line correct.
- Conflict: fill 0xBFC00000, then fetch 0xBFC00400 (same index, NUM_LINES=64) -> refill, then 0xBFC00000 misses again.
- Flush asserted during REFILL word 2 -> refill completes 4 acks, next cycle still misses and re-requests line.
- With ICACHE_STATS_EN: 1 miss + 3 hits -> Miss_Count=1, Hit_Count=4 (includes post-fill hit).

Source files
------------

// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
//   Shared definitions for the instruction-cache responder: default geometry,
//   derived address-field widths for that default geometry, the refill FSM
//   state encoding and the NOP word returned while fetch is stalled.
// ----------------------------------------------------------------------------
package icache_pkg;

  localparam int unsigned LINE_WORDS_DEF = 4;   // words per line
  localparam int unsigned NUM_LINES_DEF  = 64;  // lines in cache

  // Address split for the default geometry: | TAG | IDX | OFF |
  localparam int unsigned OFF_W = $clog2(LINE_WORDS_DEF) + 2;
  localparam int unsigned IDX_W = $clog2(NUM_LINES_DEF);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;

  // Bubble handed to fetch whenever the addressed word is unavailable.
  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_responder_if.sv
// ----------------------------------------------------------------------------
// icache_responder_if
//   Backing-memory read bus between the instruction cache and main memory.
//   Mem_Req/Mem_Addr are held stable until Mem_Ack; Mem_Data is valid with
//   Mem_Ack.
//   master : cache side (drives Mem_Req, Mem_Addr)
//   slave  : memory side (drives Mem_Ack, Mem_Data)
// ----------------------------------------------------------------------------
interface icache_responder_if;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_Data;

  modport master (output Mem_Req, output Mem_Addr, input Mem_Ack, input Mem_Data);
  modport slave  (input Mem_Req, input Mem_Addr, output Mem_Ack, output Mem_Data);
endinterface

// File: rtl/icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_refill_ctrl
//   Line-refill sequencer: IDLE/REFILL FSM, word counter, request address and
//   a sticky flag recording a flush that arrived while a refill was running.
//   Ports:
//     CLK, RESET      clock, asynchronous active-low reset
//     miss_i          lookup missed while idle (start a refill)
//     flush_i         invalidate request from the pipeline
//     line_i          line address (fetch address without offset bits)
//     mem_ack_i       memory accepted the request / data valid
//     idle_o          FSM is in IDLE (lookup allowed)
//     mem_req_o       memory read request
//     mem_addr_o      word address of the current request
//     wr_en_o         write mem data into the line at wr_word_o
//     wr_word_o       word slot being filled
//     fill_done_o     last word accepted and no flush seen: mark line valid
//     base_line_o     line address of the refill in progress
// ----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
  localparam int unsigned WSEL_W     = $clog2(LINE_WORDS),
  localparam int unsigned BASE_W     = 32 - WSEL_W - 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              miss_i,
  input  logic              flush_i,
  input  logic [BASE_W-1:0] line_i,
  input  logic              mem_ack_i,
  output logic              idle_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  output logic              wr_en_o,
  output logic [WSEL_W-1:0] wr_word_o,
  output logic              fill_done_o,
  output logic [BASE_W-1:0] base_line_o
);

  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [BASE_W-1:0] base_q;
  logic [WSEL_W-1:0] cnt_q;
  logic              flushed_q;   // flush seen during this refill
  logic              last_word;
  logic              refilling;

  assign last_word = (cnt_q == LAST_WORD);

  // State register
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d takes a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (miss_i)                 state_d = ST_REFILL;
      ST_REFILL: if (mem_ack_i && last_word) state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Outputs: the request is a pure decode of the state register, so an
  // asynchronous reset drops it immediately.
  always_comb begin
    refilling   = (state_q == ST_REFILL);
    idle_o      = (state_q == ST_IDLE);
    mem_req_o   = refilling;
    wr_en_o     = refilling && mem_ack_i;
    fill_done_o = refilling && mem_ack_i && last_word && !flushed_q && !flush_i;
  end

  // Refill datapath. The bus transaction is never aborted by a flush; the
  // flag only suppresses the valid bit at the end.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      base_q    <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (miss_i) begin
        base_q    <= line_i;
        cnt_q     <= '0;
        flushed_q <= 1'b0;
      end
    end else begin
      if (mem_ack_i) cnt_q     <= cnt_q + WSEL_W'(1);
      if (flush_i)   flushed_q <= 1'b1;
    end
  end

  assign mem_addr_o  = {base_q, cnt_q, 2'b00};
  assign wr_word_o   = cnt_q;
  assign base_line_o = base_q;

endmodule

// File: rtl/icache_responder.sv
// ----------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, read-only instruction cache in front of the main memory
//   port. Hits return the word combinationally; misses stall fetch and refill
//   the whole line word by word over the req/ack bus.
//   Ports:
//     CLK, RESET   clock, asynchronous active-low reset
//     Addr_fIF     fetch address (bits [1:0] ignored)
//     Instr_2IF    instruction word, NOP while stalled
//     Stall_2IF    addressed word not available this cycle
//     Flush        invalidate all lines
//     mem          backing-memory bus (icache_responder_if.master)
//     Hit_Count    cycles with Stall_2IF low      (ICACHE_STATS_EN only)
//     Miss_Count   refills started                (ICACHE_STATS_EN only)
//   Build option: define ICACHE_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------
module icache_responder
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Addr_fIF,
  output logic [31:0] Instr_2IF,
  output logic        Stall_2IF,
  input  logic        Flush,
  icache_responder_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] Hit_Count,
  output logic [31:0] Miss_Count
`endif
);

  localparam int unsigned L_OFF  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned L_IDX  = $clog2(NUM_LINES);
  localparam int unsigned L_TAG  = 32 - L_OFF - L_IDX;
  localparam int unsigned L_WSEL = L_OFF - 2;

  // Fetch address fields
  logic [L_TAG-1:0]  f_tag;
  logic [L_IDX-1:0]  f_idx;
  logic [L_WSEL-1:0] f_word;
  logic              unused_addr_bits;

  assign f_tag            = Addr_fIF[31 -: L_TAG];
  assign f_idx            = Addr_fIF[L_OFF +: L_IDX];
  assign f_word           = Addr_fIF[2 +: L_WSEL];
  assign unused_addr_bits = ^Addr_fIF[1:0];

  // Storage
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [L_TAG-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Refill controller
  logic                    idle, miss_start, hit;
  logic                    wr_en, fill_done;
  logic [L_WSEL-1:0]       wr_word;
  logic [L_TAG+L_IDX-1:0]  base_line;
  logic [L_IDX-1:0]        r_idx;
  logic [L_TAG-1:0]        r_tag;

  icache_refill_ctrl #(.LINE_WORDS(LINE_WORDS)) u_refill (
    .CLK         (CLK),
    .RESET       (RESET),
    .miss_i      (miss_start),
    .flush_i     (Flush),
    .line_i      (Addr_fIF[31:L_OFF]),
    .mem_ack_i   (mem.Mem_Ack),
    .idle_o      (idle),
    .mem_req_o   (mem.Mem_Req),
    .mem_addr_o  (mem.Mem_Addr),
    .wr_en_o     (wr_en),
    .wr_word_o   (wr_word),
    .fill_done_o (fill_done),
    .base_line_o (base_line)
  );

  assign r_idx = base_line[L_IDX-1:0];
  assign r_tag = base_line[L_IDX +: L_TAG];

  // Lookup: only IDLE may hit, so the line being refilled is never read early.
  assign hit        = idle && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign miss_start = idle && !hit;
  assign Stall_2IF  = !hit;
  assign Instr_2IF  = hit ? data_q[f_idx][f_word] : NOP;

  // NOTE: data and tag arrays have no reset; valid_q guards every read, and a
  // reset would prevent mapping them onto RAM.
  always_ff @(posedge CLK) begin
    if (wr_en)     data_q[r_idx][wr_word] <= mem.Mem_Data;
    if (fill_done) tag_q[r_idx]           <= r_tag;
  end

  // fill_done is already suppressed when a flush is present or was seen.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         valid_q        <= '0;
    else if (Flush)     valid_q        <= '0;
    else if (fill_done) valid_q[r_idx] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign Hit_Count  = hit_cnt_q;
  assign Miss_Count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_responder
//   Bench for icache_responder. A memory responder returns a fixed function of
//   the word address after a programmable delay; a line-level model (which
//   line base is resident in each set) predicts hit/miss, stall length,
//   the request address sequence and the returned instruction.
// ----------------------------------------------------------------------------
module tb_icache_responder;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_responder_if mem_if ();

  icache_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Addr_fIF  (addr),
    .Instr_2IF (instr),
    .Stall_2IF (stall),
    .Flush     (flush),
    .mem       (mem_if)
`ifdef ICACHE_STATS_EN
    ,
    .Hit_Count (hit_count),
    .Miss_Count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Memory responder state
  int          ack_delay   = 0;
  bit          spurious_en = 1'b0;
  int          wait_cnt    = 0;
  int          stab_bad    = 0;
  logic [31:0] held_addr;
  logic [31:0] acked [$];

  // Line-level cache model
  bit          mvalid [NL];
  logic [31:0] mline  [NL];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
  endtask

  // Backing memory: ack after ack_delay wait cycles, data is mem_fn(address).
  initial begin
    mem_if.Mem_Ack  = 1'b0;
    mem_if.Mem_Data = '0;
    forever begin
      @(posedge CLK); #1;
      if (mem_if.Mem_Req === 1'b1) begin
        if (wait_cnt == 0) held_addr = mem_if.Mem_Addr;
        else if (mem_if.Mem_Addr !== held_addr) stab_bad++;
        if (wait_cnt >= ack_delay) begin
          mem_if.Mem_Ack  = 1'b1;
          mem_if.Mem_Data = mem_fn(mem_if.Mem_Addr);
          acked.push_back(mem_if.Mem_Addr);
          wait_cnt = 0;
        end else begin
          mem_if.Mem_Ack  = 1'b0;
          mem_if.Mem_Data = $urandom;
          wait_cnt++;
        end
      end else begin
        mem_if.Mem_Ack  = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_if.Mem_Data = $urandom;
        wait_cnt = 0;
      end
    end
  end

  // One fetch transaction: drive the address (unless pre_driven, meaning the
  // current negedge is already the first cycle of this fetch), count stall
  // cycles until the word arrives, and compare against the model.
  task automatic do_fetch(input string name, input logic [31:0] a, input int delay,
                          input int flush_after, input bit pre_driven);
    logic [31:0] base, got, req_at_hit;
    logic [31:0] exp_q [$];
    int  idx, exp_stall, stalls, fa, stab0;
    bit  exp_hit, nop_bad, flushed, fire, done, list_bad;

    base    = a & ~32'(4 * LW - 1);
    idx     = int'((a / 32'(4 * LW)) % 32'(NL));
    exp_hit = mvalid[idx] && (mline[idx] == base);
    fa      = exp_hit ? 0 : flush_after;
    if (exp_hit) exp_stall = 0;
    else begin
      exp_stall = 1 + LW * (delay + 1);
      for (int w = 0; w < LW; w++) exp_q.push_back(base + 32'(4 * w));
      if (fa > 0) begin
        exp_stall = 2 * exp_stall;
        for (int w = 0; w < LW; w++) exp_q.push_back(base + 32'(4 * w));
      end
    end

    ack_delay = delay;
    acked.delete();
    stab0 = stab_bad;
    stalls = 0; nop_bad = 0; flushed = 0; done = 0;
    got = 'x; req_at_hit = 'x;

    if (!pre_driven) begin
      @(posedge CLK); #1;
      addr = a;
      @(negedge CLK);
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stall === 1'b0) begin
        got        = instr;
        req_at_hit = 32'(mem_if.Mem_Req);
        done       = 1'b1;
        break;
      end
      stalls++;
      if (instr !== 32'h0) nop_bad = 1'b1;
      fire = !flushed && (fa > 0) && (acked.size() == fa);
      @(posedge CLK); #1;
      flush = fire;
      if (fire) flushed = 1'b1;
      @(negedge CLK);
    end
    flush = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s.timeout: stall still high after %0d cycles, want release", name, stalls);
    end
    total++;
    if (stalls != exp_stall) begin
      bad++;
      $display("FAIL %s.stall_cycles: got %0d want %0d (addr %h)", name, stalls, exp_stall, a);
    end
    total++;
    if (got !== mem_fn(a)) begin
      bad++;
      $display("FAIL %s.instr: got %h want %h (addr %h)", name, got, mem_fn(a), a);
    end
    total++;
    if (nop_bad) begin
      bad++;
      $display("FAIL %s.nop_during_stall: got non-zero Instr_2IF want 00000000", name);
    end
    total++;
    if (req_at_hit !== 32'd0) begin
      bad++;
      $display("FAIL %s.req_at_hit: got Mem_Req=%0d want 0", name, req_at_hit);
    end
    list_bad = (acked.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !list_bad; i++)
      if (acked[i] !== exp_q[i]) list_bad = 1'b1;
    total++;
    if (list_bad) begin
      bad++;
      $display("FAIL %s.req_addrs: got %0d requests (first %h) want %0d (first %h)", name,
               acked.size(), (acked.size() > 0) ? acked[0] : 32'hx,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 32'hx);
    end
    total++;
    if (stab_bad != stab0) begin
      bad++;
      $display("FAIL %s.addr_stable: got %0d address changes while waiting want 0", name,
               stab_bad - stab0);
    end

    if (!exp_hit) begin
      if (fa > 0) model_clear();
      mvalid[idx] = 1'b1;
      mline[idx]  = base;
    end
  endtask

  task automatic test_reset();
    addr = 32'hBFC0_0000;
    repeat (3) @(negedge CLK);
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL reset.stall: got %b want 1", stall); end
    total++;
    if (instr !== 32'h0) begin bad++; $display("FAIL reset.instr: got %h want 00000000", instr); end
    total++;
    if (mem_if.Mem_Req !== 1'b0) begin bad++; $display("FAIL reset.req: got %b want 0", mem_if.Mem_Req); end
    total++;
    if (mem_if.Mem_Addr !== 32'h0) begin
      bad++; $display("FAIL reset.addr: got %h want 00000000", mem_if.Mem_Addr);
    end
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++; $display("FAIL reset.stats: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
`endif
    RESET = 1'b1;
    do_fetch("first_fill", 32'hBFC0_0000, 0, 0, 1'b1);
  endtask

  task automatic test_fill_sweep();
    for (int w = 1; w < LW; w++) do_fetch("sweep", 32'hBFC0_0000 + 32'(4 * w), 0, 0, 1'b0);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    @(posedge CLK); #1;
    addr = 32'h0000_7000;
    @(negedge CLK);
    total++;
    if (hit_count !== 32'd4) begin bad++; $display("FAIL stats.hit: got %0d want 4", hit_count); end
    total++;
    if (miss_count !== 32'd1) begin bad++; $display("FAIL stats.miss: got %0d want 1", miss_count); end
    do_fetch("stats_tail", 32'h0000_7000, 0, 0, 1'b1);
  endtask
`endif

  task automatic test_delayed_ack();
    do_fetch("delay3", 32'h0001_0024, 3, 0, 1'b0);
    do_fetch("delay3_hit", 32'h0001_002C, 0, 0, 1'b0);
  endtask

  task automatic test_conflict();
    do_fetch("conflict_a", 32'hBFC0_0400, 0, 0, 1'b0);
    do_fetch("conflict_b", 32'hBFC0_0000, 0, 0, 1'b0);
    do_fetch("conflict_b_hit", 32'hBFC0_0008, 0, 0, 1'b0);
  endtask

  task automatic test_flush_refill();
    do_fetch("flush_refill", 32'h0002_0050, 0, 2, 1'b0);
    do_fetch("flush_refill_hit", 32'h0002_0054, 0, 0, 1'b0);
  endtask

  task automatic test_flush_idle();
    do_fetch("flush_idle_pre", 32'h0002_0058, 0, 0, 1'b0);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(negedge CLK);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle.same_cycle: got stall=%b want 0", stall); end
    @(posedge CLK); #1;
    flush = 1'b0;
    model_clear();
    @(negedge CLK);
    do_fetch("flush_idle_refetch", 32'h0002_0058, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_refill();
    bit seen = 1'b0;
    ack_delay = 0;
    acked.delete();
    @(posedge CLK); #1;
    addr = 32'h0003_0120;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = (acked.size() >= 2);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_reset.wait: got %0d acks want 2", acked.size()); end
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    total++;
    if (mem_if.Mem_Req !== 1'b0) begin bad++; $display("FAIL mid_reset.req_drop: got %b want 0", mem_if.Mem_Req); end
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL mid_reset.stall: got %b want 1", stall); end
    model_clear();
    @(negedge CLK);
    RESET = 1'b1;
    do_fetch("mid_reset_refetch", 32'h0003_0120, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          fa;
    for (int n = 0; n < 40; n++) begin
      a = 32'h0040_0000 + 32'($urandom_range(0, 2)) * 32'h400 +
          32'($urandom_range(0, 7)) * 32'd16 + 32'($urandom_range(0, LW - 1)) * 32'd4;
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LW - 1)) : 0;
      do_fetch("random", a, int'($urandom_range(0, 2)), fa, 1'b0);
    end
  endtask

  initial begin
    RESET = 1'b0;
    flush = 1'b0;
    addr  = 32'h0;
    model_clear();
    test_reset();
    test_fill_sweep();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    spurious_en = 1'b1;
    test_delayed_ack();
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
